// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - button/soft-reset inputs, staged reset outputs and cause vector
interface reset_sequencer_if #(
  parameter int NUM_BUTTONS = 2,
  parameter int NUM_STAGES  = 3
);
  logic [NUM_BUTTONS-1:0] but_n;
  logic                   soft_req;
  logic                   cause_clr;
  logic [NUM_STAGES-1:0]  rst_out;
  logic                   rst_done;
  logic [NUM_BUTTONS+1:0] cause;

  modport master (
    output but_n, soft_req, cause_clr,
    input  rst_out, rst_done, cause
  );

  modport slave (
    input  but_n, soft_req, cause_clr,
    output rst_out, rst_done, cause
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - debounced multi-source reset merger with staggered stage release
module reset_sequencer #(
  parameter int HOLD_CYCLES      = 5000000,
  parameter int STAGE_GAP_CYCLES = 1000,
  parameter int NUM_STAGES       = 3,
  parameter int NUM_BUTTONS      = 2,
  parameter int DEBOUNCE_CYCLES  = 100000
) (
  input logic              clk,
  input logic              reset,
  reset_sequencer_if.slave bus
);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
  localparam int GAP_W   = $clog2(STAGE_GAP_CYCLES) + 1;
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int STG_W   = $clog2(NUM_STAGES) + 1;
  localparam int CAUSE_W = NUM_BUTTONS + 2;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  // Button path: synchroniser, debounced level and its one-cycle-old copy
  logic [NUM_BUTTONS-1:0] sync1;
  logic [NUM_BUTTONS-1:0] sync2;
  logic [NUM_BUTTONS-1:0] deb;
  logic [NUM_BUTTONS-1:0] deb_prev;
  logic [DEB_W-1:0]       deb_cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] press_evt;
  logic                   any_pressed;
  logic                   trigger;

  // Sequencer registers and their next values
  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [STG_W-1:0]       stage_q, stage_d;
  logic [NUM_STAGES-1:0]  rst_out_q, rst_out_d;
  logic                   done_q, done_d;
  logic [CAUSE_W-1:0]     cause_q, cause_d;

  // A press is the debounced level going released -> pressed
  assign press_evt   = deb_prev & ~deb;
  assign any_pressed = ~&deb;
  assign trigger     = bus.soft_req | (|press_evt);

  // Synchronise each button and accept a new level only after it has been stable long enough
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '1;
      sync2    <= '1;
      deb      <= '1;
      deb_prev <= '1;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1    <= bus.but_n;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Next-state logic: triggers restart the hold, otherwise count hold then release stages in order
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    stage_d   = stage_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    cause_d   = (cause_q & ~{CAUSE_W{bus.cause_clr}}) | {press_evt, bus.soft_req, 1'b0};

    if (trigger) begin
      state_d   = S_HOLD;
      hold_d    = '0;
      gap_d     = '0;
      stage_d   = '0;
      rst_out_d = '1;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (any_pressed) begin
            hold_d = '0;
          end else if (hold_q == HOLD_LAST) begin
            rst_out_d = rst_out_q << 1;
            gap_d     = '0;
            stage_d   = STG_W'(1);
            if (NUM_STAGES == 1) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        S_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_d     = '0;
            rst_out_d = rst_out_q << 1;
            stage_d   = stage_q + STG_W'(1);
            if (stage_q == STG_LAST) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        S_RUN: begin
          rst_out_d = '0;
          done_d    = 1'b1;
        end
        default: begin
          state_d   = S_HOLD;
          hold_d    = '0;
          gap_d     = '0;
          stage_d   = '0;
          rst_out_d = '1;
          done_d    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; system reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HOLD;
      hold_q    <= '0;
      gap_q     <= '0;
      stage_q   <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      cause_q   <= CAUSE_W'(1);
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      stage_q   <= stage_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
    end
  end

  assign bus.rst_out  = rst_out_q;
  assign bus.rst_done = done_q;
  assign bus.cause    = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized and directed bench for reset_sequencer against a timing model
module tb_reset_sequencer;
  localparam int HOLD = 20;
  localparam int GAP  = 4;
  localparam int NS   = 3;
  localparam int NB   = 2;
  localparam int DEB  = 5;

  logic clk = 1'b0;
  logic reset;

  reset_sequencer_if #(.NUM_BUTTONS(NB), .NUM_STAGES(NS)) bus ();

  reset_sequencer #(
    .HOLD_CYCLES      (HOLD),
    .STAGE_GAP_CYCLES (GAP),
    .NUM_STAGES       (NS),
    .NUM_BUTTONS      (NB),
    .DEBOUNCE_CYCLES  (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: button pipeline, elapsed edges since the hold interval began, cause bits
  logic [NB-1:0]   m_s1, m_s2, m_deb, m_prev;
  int              m_run [NB];
  int              m_el;
  logic [NB+1:0]   m_cause;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NS-1:0] exp_rst_out(input int el);
    int rel;
    logic [NS-1:0] ones;
    ones = '1;
    if (el < HOLD) return ones;
    rel = 1 + (el - HOLD) / GAP;
    if (rel > NS) rel = NS;
    return ones << rel;
  endfunction

  function automatic logic exp_done(input int el);
    return (el >= HOLD + (NS - 1) * GAP);
  endfunction

  task automatic model_step();
    logic [NB-1:0] press;
    logic [NB-1:0] nd;
    if (reset) begin
      m_s1 = '1; m_s2 = '1; m_deb = '1; m_prev = '1;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      m_el = 0;
      m_cause = 4'b0001;
    end else begin
      press = m_prev & ~m_deb;
      m_cause = (bus.cause_clr ? 4'b0000 : m_cause) | {press, bus.soft_req, 1'b0};
      if (bus.soft_req || press != 0 || m_deb != '1) m_el = 0;
      else if (m_el < 1000) m_el++;
      nd = m_deb;
      for (int i = 0; i < NB; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            nd[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_prev = m_deb;
      m_deb  = nd;
      m_s2   = m_s1;
      m_s1   = bus.but_n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("rst_out", 32'(bus.rst_out), 32'(exp_rst_out(m_el)));
    check("rst_done", 32'(bus.rst_done), 32'(exp_done(m_el)));
    check("cause", 32'(bus.cause), 32'(m_cause));
  endtask

  int btn_left [NB];
  logic [NB+1:0] saved_cause;
  bit reached;

  initial begin
    reset = 1'b1;
    bus.but_n = '1;
    bus.soft_req = 1'b0;
    bus.cause_clr = 1'b0;

    // 1: power-up
    repeat (3) tick();
    check("t1_reset_rst_out", 32'(bus.rst_out), 32'h7);
    check("t1_reset_cause", 32'(bus.cause), 32'h1);
    reset = 1'b0;
    for (int e = 1; e <= 28; e++) begin
      tick();
      if (e == 19) check("t1_e19", 32'(bus.rst_out), 32'h7);
      if (e == 20) check("t1_e20", 32'(bus.rst_out), 32'h6);
      if (e == 23) check("t1_e23", 32'(bus.rst_out), 32'h6);
      if (e == 24) check("t1_e24", 32'(bus.rst_out), 32'h4);
      if (e == 27) check("t1_e27_done", 32'(bus.rst_done), 32'h0);
      if (e == 28) begin
        check("t1_e28", 32'(bus.rst_out), 32'h0);
        check("t1_e28_done", 32'(bus.rst_done), 32'h1);
        check("t1_cause", 32'(bus.cause), 32'h1);
      end
    end
    repeat (3) tick();

    // 2: glitch shorter than the debounce window
    saved_cause = bus.cause;
    bus.but_n[0] = 1'b0;
    repeat (3) tick();
    bus.but_n[0] = 1'b1;
    repeat (12) tick();
    check("t2_rst_out", 32'(bus.rst_out), 32'h0);
    check("t2_done", 32'(bus.rst_done), 32'h1);
    check("t2_cause", 32'(bus.cause), 32'(saved_cause));

    // 3: held button extends the hold interval
    bus.but_n[1] = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 7) check("t3_k7", 32'(bus.rst_out), 32'h0);
      if (k == 8) check("t3_k8", 32'(bus.rst_out), 32'h7);
      if (k == 50) begin
        check("t3_held", 32'(bus.rst_out), 32'h7);
        check("t3_cause3", 32'(bus.cause[3]), 32'h1);
      end
    end
    bus.but_n[1] = 1'b1;
    for (int r = 1; r <= 35; r++) begin
      tick();
      if (r == 26) check("t3_r26", 32'(bus.rst_out), 32'h7);
      if (r == 27) check("t3_r27", 32'(bus.rst_out), 32'h6);
      if (r == 31) check("t3_r31", 32'(bus.rst_out), 32'h4);
      if (r == 35) check("t3_r35", 32'(bus.rst_out), 32'h0);
    end

    // 4: soft reset during release
    bus.soft_req = 1'b1;
    tick();
    bus.soft_req = 1'b0;
    reached = 1'b0;
    for (int w = 0; w < 100 && !reached; w++) begin
      tick();
      if (bus.rst_out == 3'b110) reached = 1'b1;
    end
    check("t4_reach_110", 32'(reached), 32'h1);
    bus.soft_req = 1'b1;
    tick();
    bus.soft_req = 1'b0;
    check("t4_reassert", 32'(bus.rst_out), 32'h7);
    check("t4_cause1", 32'(bus.cause[1]), 32'h1);
    for (int s = 1; s <= 28; s++) begin
      tick();
      if (s == 19) check("t4_s19", 32'(bus.rst_out), 32'h7);
      if (s == 20) check("t4_s20", 32'(bus.rst_out), 32'h6);
      if (s == 24) check("t4_s24", 32'(bus.rst_out), 32'h4);
      if (s == 28) check("t4_s28", 32'(bus.rst_out), 32'h0);
    end

    // 5: cause clear, alone and together with a set
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    check("t5_clr", 32'(bus.cause), 32'h0);
    bus.cause_clr = 1'b1;
    bus.soft_req = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    bus.soft_req = 1'b0;
    check("t5_set_wins", 32'(bus.cause), 32'h2);
    check("t5_restart", 32'(bus.rst_out), 32'h7);

    // 6: reset during hold with a button pressed
    bus.but_n[0] = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    repeat (2) tick();
    check("t6_cause", 32'(bus.cause), 32'h1);
    check("t6_rst_out", 32'(bus.rst_out), 32'h7);
    reset = 1'b0;
    bus.but_n[0] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 19) check("t6_e19", 32'(bus.rst_out), 32'h7);
      if (e == 20) check("t6_e20", 32'(bus.rst_out), 32'h6);
    end

    // Randomized traffic against the model
    for (int i = 0; i < NB; i++) btn_left[i] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NB; i++) begin
        if (btn_left[i] == 0) begin
          bus.but_n[i] = ($urandom_range(0, 2) != 0);
          btn_left[i] = $urandom_range(1, 12);
        end else begin
          btn_left[i]--;
        end
      end
      bus.soft_req  = ($urandom_range(0, 59) == 0);
      bus.cause_clr = ($urandom_range(0, 39) == 0);
      reset         = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    bus.soft_req = 1'b0;
    bus.cause_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor of the board-level power-on/button reset generator.
- Merges the system reset, N debounced active-low push-buttons and a soft-reset request into one hold timer.
- Releases NUM_STAGES reset outputs in a fixed staggered order (e.g. clocks, then memory, then CPU/video), and records a sticky reset-cause vector for firmware/debug.

Parameters:
- HOLD_CYCLES, 5000000, clocks all outputs stay asserted after the last trigger clears (500 ms at 10 MHz); must be >=1.
- STAGE_GAP_CYCLES, 1000, clocks between successive stage releases; must be >=1.
- NUM_STAGES, 3, number of sequenced reset outputs; must be >=1.
- NUM_BUTTONS, 2, number of active-low button inputs; must be >=1.
- DEBOUNCE_CYCLES, 100000, consecutive stable synchronised samples required to accept a button level change (10 ms); must be >=1.

Ports:
- clk  in  1  system clock, 10 MHz nominal.
- reset  in  1  synchronous, active-high system reset (one clock; reset is synchronous and active-high).
- but_n  in  NUM_BUTTONS  asynchronous active-low buttons.
- soft_req  in  1  single-cycle soft-reset request, clk domain.
- cause_clr  in  1  single-cycle clear of cause.
- rst_out  out  NUM_STAGES  active-high resets; bit 0 released first.
- rst_done  out  1  high when all stages are released.
- cause  out  NUM_BUTTONS+2  sticky cause bits:
  - bit 0: reset input;
  - bit 1: soft_req;
  - bit 2+i: but_n[i].

Behaviour:
- Counter widths: $clog2 of the largest count + 1. Counters saturate and never wrap.
- While reset is high, on every edge:
  - state=HOLD, hold counter=0, stage index=0;
  - rst_out=all ones, rst_done=0, cause={0..0,1};
  - button synchronisers load 1, debounced level=released (1), debounce counters=0.
- Button path, per button:
  - 2-FF synchroniser, then debounce counter.
  - The counter increments while the synced value differs from the debounced level and clears otherwise.
  - At DEBOUNCE_CYCLES the debounced level flips and the counter clears.
  - A press event is the 1->0 transition of the debounced level.
- Triggers:
  - Trigger sources are press events and soft_req.
  - On a trigger edge: state=HOLD, hold counter=0, stage index=0, rst_out=all ones from the next cycle.
  - The corresponding cause bit is set.
  - Multiple simultaneous triggers set all their bits and cause one restart.
- Hold extension: while any debounced button level is pressed, the hold counter is held at 0. The hold interval starts when the last button is released.
- FSM states:
  - HOLD:
    - hold counter increments each clock (no button pressed).
    - When the counter reaches HOLD_CYCLES-1, go to RELEASE and clear rst_out[0] on that edge.
    - Consequence: with reset low from edge 1, rst_out[0] is first low after edge HOLD_CYCLES.
  - RELEASE:
    - Gap counter counts STAGE_GAP_CYCLES per stage.
    - Stage k clears exactly HOLD_CYCLES + k*STAGE_GAP_CYCLES edges after the hold start.
    - Clearing the last stage moves the FSM to RUN.
    - If NUM_STAGES=1, go HOLD->RUN directly.
  - RUN: rst_out=0, rst_done=1, registered and asserted on the same edge the last stage clears. Waits for a trigger.
- Output guarantees:
  - rst_out bits are registered and glitch-free.
  - A lower-index stage is never asserted while a higher-index stage is released. Re-assertion of all bits is simultaneous.
- Cause vector:
  - Bits are sticky.
  - cause_clr clears all bits on the next edge.
  - If a set and a clear occur in the same cycle, the set wins for that bit.
  - reset overrides everything.
- Priority: reset > trigger > normal counting. A trigger during HOLD restarts the hold counter.

Test Plan (HOLD_CYCLES=20, STAGE_GAP_CYCLES=4, NUM_STAGES=3, NUM_BUTTONS=2, DEBOUNCE_CYCLES=5):
1. Power-up: reset high 3 clocks, then low. Required:
   - rst_out=111 through edge 19;
   - 110 after edge 20, 100 after edge 24;
   - 000 with rst_done=1 after edge 28;
   - cause=0001.
2. Glitch: in RUN, but_n[0] low for 3 clocks. Required: rst_out stays 000, rst_done stays 1, cause unchanged.
3. Held button:
   - Stimulus: in RUN, but_n[1] low for 50 clocks, then high.
   - Required while pressed:
     - rst_out=111 starting 2+5+1 clocks after the press, rst_done=0;
     - rst_out stays 111 for the whole press;
     - cause bit 3 is set.
   - Required after release: rst_out[0] drops 2+5+20 clocks after but_n rises, then the stages follow 4 clocks apart.
4. Soft reset during release: soft_req pulses 1 clock after rst_out[0] has released (rst_out=110). Required: rst_out=111 next cycle, the full 20+4+4 sequence restarts, cause bit 1 is set.
5. Cause clear:
   - cause_clr alone: cause=0000 next cycle.
   - cause_clr and soft_req in the same cycle: cause=0010, and a reset sequence starts.
6. Reset mid-operation: reset asserted during HOLD while but_n[0] is pressed. Required:
   - cause=0001, rst_out=111, debounced state released;
   - after reset falls (button released), rst_out[0] drops at edge 20.
